// File: rtl/carregador_instrucoes.sv
// Boot loader for the MIPS instruction memory.
// Takes a byte stream over valid/ready, reads a 2-byte big-endian word COUNT,
// then assembles COUNT big-endian 32-bit words and writes them to consecutive
// word addresses starting at 0. The CPU is held until a load completes cleanly.
//
// Handshake: a byte moves on a rising edge where in_valid and in_ready are both 1.
// in_ready is registered and is 1 only in HDR_HI, HDR_LO and DATA. A source
// presenting a byte while in_ready is 0 must hold it until it is taken.
module carregador_instrucoes #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Memory depth in words, widened so COUNT (up to 65535) compares cleanly.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state;
    state_t            next_state;
    logic [15:0]       count;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       wdata;

    logic              xfer;
    logic              start_acc;
    logic [15:0]       hdr_count;
    logic              last_word;

    logic              in_ready_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_d;
    logic              cpu_hold_d;
    logic              done_d;
    logic              error_d;
    logic [ADDR_W:0]   words_loaded_d;

    assign xfer      = in_valid & in_ready;
    // start counts only when no load is in flight.
    assign start_acc = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    // Full COUNT as it will be once the low header byte is captured.
    assign hdr_count = {count[15:8], in_data};
    // word_idx never wraps: the last legal index is DEPTH-1.
    assign last_word = (32'(word_idx) == (32'(count) - 32'd1));

    assign mem_wdata = wdata;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_acc) next_state = HDR_HI;
            HDR_HI:  if (xfer) next_state = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (hdr_count == 16'd0)          next_state = DONE;
                    else if (32'(hdr_count) > DEPTH) next_state = ERR;
                    else                             next_state = DATA;
                end
            end
            DATA:    if (xfer && (byte_idx == 2'd3)) next_state = WRITE;
            WRITE:   next_state = last_word ? DONE : DATA;
            DONE:    next_state = start_acc ? HDR_HI : IDLE;
            ERR:     if (start_acc) next_state = HDR_HI;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: values the output registers take on the next edge.
    always_comb begin
        in_ready_d     = (next_state == HDR_HI) | (next_state == HDR_LO) | (next_state == DATA);
        mem_we_d       = (next_state == WRITE);
        done_d         = (next_state == DONE);
        mem_waddr_d    = mem_waddr;
        words_loaded_d = words_loaded;
        cpu_hold_d     = cpu_hold;
        error_d        = error;
        if (next_state == WRITE) begin
            mem_waddr_d    = word_idx;
            words_loaded_d = (ADDR_W+1)'(word_idx) + 1'b1;
        end
        if (next_state == DONE) cpu_hold_d = 1'b0;
        if (next_state == ERR)  error_d    = 1'b1;
        if (start_acc) begin
            cpu_hold_d     = 1'b1;
            error_d        = 1'b0;
            words_loaded_d = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            in_ready     <= in_ready_d;
            mem_we       <= mem_we_d;
            mem_waddr    <= mem_waddr_d;
            cpu_hold     <= cpu_hold_d;
            done         <= done_d;
            error        <= error_d;
            words_loaded <= words_loaded_d;
        end
    end

    // Header, byte/word counters and word assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            wdata    <= '0;
        end else begin
            if (start_acc) begin
                count    <= '0;
                byte_idx <= '0;
                word_idx <= '0;
            end
            case (state)
                HDR_HI: if (xfer) count[15:8] <= in_data;
                HDR_LO: if (xfer) count[7:0]  <= in_data;
                DATA: begin
                    if (xfer) begin
                        wdata    <= {wdata[23:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE:  if (!last_word) word_idx <= word_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Bench for carregador_instrucoes: drives byte streams, predicts every memory
// write into a queue and compares the writes the loader actually issues.
module tb_carregador_instrucoes;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    logic [ADDR_W-1:0] last_addr;

    // Expected writes: {address, data}.
    logic [ADDR_W+32-1:0] exp_q[$];

    carregador_instrucoes #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every mem_we must match the oldest predicted write.
    always @(negedge clk) begin
        if (mem_we) begin
            logic [ADDR_W+32-1:0] e;
            we_cnt++;
            last_addr = mem_waddr;
            check("we_vs_ready", in_ready, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_waddr, mem_wdata}, 0);
            end else begin
                e = exp_q.pop_front();
                check("waddr", mem_waddr, e[ADDR_W+31:32]);
                check("wdata", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_waddr"}, mem_waddr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // Driver tasks. Each starts and ends aligned to clock edges.
    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("byte_timeout", 0, 1);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] cnt, input int gap);
        send_byte(cnt[15:8], gap);
        send_byte(cnt[7:0], gap);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input int gap);
        exp_q.push_back({addr, w});
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_cpu_hold_released"}, cpu_hold, 0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, done, 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int we0;
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Two-word load, back to back.
        pulse_start();
        check("t1_hold_on_start", cpu_hold, 1);
        check("t1_ready_hdr", in_ready, 1);
        send_hdr(16'd2, 0);
        send_word(8'd0, 32'h20080001, 0);
        send_word(8'd1, 32'h01095020, 0);
        wait_done("t1");
        check("t1_words_loaded", words_loaded, 2);
        check("t1_queue_empty", exp_q.size(), 0);

        // Same stream with 3-cycle gaps between bytes.
        pulse_start();
        check("t2_hold_on_start", cpu_hold, 1);
        check("t2_words_cleared", words_loaded, 0);
        send_hdr(16'd2, 3);
        send_word(8'd0, 32'h20080001, 3);
        send_word(8'd1, 32'h01095020, 3);
        wait_done("t2");
        check("t2_words_loaded", words_loaded, 2);
        check("t2_queue_empty", exp_q.size(), 0);

        // Oversized header goes to ERR; then a good 1-word load clears it.
        we0 = we_cnt;
        pulse_start();
        send_hdr(16'd257, 0);
        idle_bus();
        repeat (4) @(negedge clk);
        check("t3_error", error, 1);
        check("t3_hold", cpu_hold, 1);
        check("t3_ready_low", in_ready, 0);
        check("t3_no_writes", we_cnt - we0, 0);
        pulse_start();
        check("t3_error_cleared", error, 0);
        send_hdr(16'd1, 0);
        send_word(8'd0, $urandom(), 0);
        wait_done("t3");
        check("t3_error_after", error, 0);
        check("t3_words_loaded", words_loaded, 1);

        // Full-depth load: 256 words, last at FF, no wrap.
        we0 = we_cnt;
        pulse_start();
        send_hdr(16'd256, 0);
        for (int i = 0; i < 256; i++) send_word(ADDR_W'(i), $urandom(), (i % 16 == 5) ? $urandom_range(0, 2) : 0);
        wait_done("t4");
        check("t4_write_count", we_cnt - we0, 256);
        check("t4_last_addr", last_addr, 8'hFF);
        check("t4_words_loaded", words_loaded, 256);
        check("t4_queue_empty", exp_q.size(), 0);

        // Zero-word load.
        we0 = we_cnt;
        pulse_start();
        send_hdr(16'd0, 0);
        wait_done("t5");
        check("t5_no_writes", we_cnt - we0, 0);
        check("t5_words_loaded", words_loaded, 0);

        // start during DATA is ignored: load continues unchanged.
        pulse_start();
        send_hdr(16'd2, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        pulse_start();
        check("t5_still_data", dbg_state, 3);
        exp_q.push_back({8'd0, 32'hA1B2C3D4});
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        send_word(8'd1, 32'h0BADF00D, 1);
        wait_done("t5b");
        check("t5b_queue_empty", exp_q.size(), 0);

        // Reset after 6 data bytes (one word written, second half-built).
        pulse_start();
        send_hdr(16'd4, 0);
        send_word(8'd0, 32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        check("t6_words_mid", words_loaded, 1);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_reset_values("t6");
        reset = 1'b0;
        pulse_start();
        send_hdr(16'd1, 0);
        send_word(8'd0, 32'hCAFEF00D, 0);
        wait_done("t6");
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_words_loaded", words_loaded, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
